// File: rtl/loopback_rx_err_checker.sv
// Loopback receive checker: aligns to an incrementing-count pattern, tracks lock and accumulates
// saturating word/error counts. Define LOOPBACK_ERR_BITCOUNT_EN to count errored bits instead of words.
module loopback_rx_err_checker #(
  parameter int DATA_WIDTH  = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_link_up,
  input  logic                  cnt_clr,
  output logic [31:0]           err_cnt,
  output logic [31:0]           word_cnt,
  output logic                  locked,
  output logic                  err_flag
);

  typedef enum logic [1:0] {IDLE, ALIGN, CHECK} state_t;

  localparam logic [7:0] LOSS_LAST = 8'(LOSS_THRESH - 1);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] expected_reg;
  logic [7:0]            consec_reg;
  logic [DATA_WIDTH-1:0] xor_q;
  logic                  hit_q;
  logic                  bad_q;
  logic [31:0]           err_cnt_reg;
  logic [31:0]           word_cnt_reg;
  logic [31:0]           err_cnt_next;
  logic [31:0]           word_cnt_next;
  logic [31:0]           err_inc;
  logic [32:0]           err_sum;
  logic [32:0]           word_sum;
  logic                  compare;
  logic                  mismatch;

  assign compare  = rx_valid && rx_link_up && (state_reg == CHECK);
  assign mismatch = (rx_data != expected_reg);

  // Lock FSM; the pattern advances from the expected value, not the received one.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_reg    <= IDLE;
      locked       <= 1'b0;
      expected_reg <= '0;
      consec_reg   <= '0;
    end else if (!rx_link_up) begin
      state_reg  <= IDLE;
      locked     <= 1'b0;
      consec_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= ALIGN;
        end
        ALIGN: begin
          if (rx_valid) begin
            expected_reg <= rx_data + DATA_WIDTH'(1);
            state_reg    <= CHECK;
            locked       <= 1'b1;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            expected_reg <= expected_reg + DATA_WIDTH'(1);
            if (!mismatch) begin
              consec_reg <= '0;
            end else if (consec_reg >= LOSS_LAST) begin
              state_reg  <= ALIGN;
              locked     <= 1'b0;
              consec_reg <= '0;
            end else begin
              consec_reg <= consec_reg + 8'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      xor_q <= '0;
      hit_q <= 1'b0;
    end else begin
      xor_q <= compare ? (rx_data ^ expected_reg) : '0;
      hit_q <= compare;
    end
  end

  assign bad_q    = hit_q && (xor_q != '0);
  assign err_flag = bad_q;

`ifdef LOOPBACK_ERR_BITCOUNT_EN
  always_comb begin
    err_inc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      err_inc = err_inc + 32'(xor_q[i]);
    end
  end
`else
  assign err_inc = 32'd1;
`endif

  // 33-bit sums so a carry out clamps the counter instead of wrapping it.
  assign err_sum  = {1'b0, err_cnt_reg} + {1'b0, err_inc};
  assign word_sum = {1'b0, word_cnt_reg} + 33'd1;

  always_comb begin
    err_cnt_next  = err_cnt_reg;
    word_cnt_next = word_cnt_reg;
    if (cnt_clr) begin
      err_cnt_next  = '0;
      word_cnt_next = '0;
    end else begin
      if (bad_q) begin
        err_cnt_next = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
      end
      if (hit_q) begin
        word_cnt_next = word_sum[32] ? 32'hFFFF_FFFF : word_sum[31:0];
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      err_cnt_reg  <= '0;
      word_cnt_reg <= '0;
    end else begin
      err_cnt_reg  <= err_cnt_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  assign err_cnt  = err_cnt_reg;
  assign word_cnt = word_cnt_reg;

endmodule
